mul_add_seq: RTL and testbench
==============================

MUL_ADD_SEQ -- requirements
Module: mul_add_seq

Interface
REQ-001 SHALL have parameter N_NEURON, default 46: number of neuron outputs sequenced per pass (1..64).
REQ-002 SHALL have parameter CORE_LAT, default 4: cycles from CORE_EN to valid CORE_RESULT (1..15).
REQ-003 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-004 SHALL have port RESET_X, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port START, input, 1: one-cycle request to begin a pass.
REQ-006 SHALL have port BUSY, output, 1: pass in progress.
REQ-007 SHALL have port CORE_EN, output, 1: one-cycle issue strobe to the shared mul_add_core.
REQ-008 SHALL have port W_SEL, output, 6: weight/bias set index applied to the core.
REQ-009 SHALL have port CORE_RESULT, input, 32: signed core output.
REQ-010 SHALL have port RES_VALID, output, 1: result available.
REQ-011 SHALL have port RES_READY, input, 1: consumer accepts result.
REQ-012 SHALL have port RES_IDX, output, 6: neuron index of RES_DATA.
REQ-013 SHALL have port RES_DATA, output, 32: captured result.
REQ-014 SHALL have port DONE, output, 1: one-cycle pulse, pass complete.
REQ-015 SHALL have ports MAX_IDX (output, 6) and MAX_VAL (output, 32): argmax of the pass.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT.
REQ-017 IDLE: START=1 -> neuron counter n=0, BUSY=1, next ISSUE; START ignored in all other states.
REQ-018 ISSUE: CORE_EN=1 and W_SEL=n for exactly one cycle; latency counter cleared; next WAIT.
REQ-019 W_SEL SHALL hold n from ISSUE until the OUT handshake for n.
REQ-020 WAIT: counter increments each cycle; on the CORE_LAT-th cycle after the CORE_EN cycle, CORE_RESULT captured into RES_DATA, RES_IDX=n; next OUT.
REQ-021 OUT: RES_VALID=1, RES_DATA/RES_IDX stable until RES_VALID&RES_READY.
REQ-022 On handshake with n<N_NEURON-1: n increments, next ISSUE (no idle cycle).
REQ-023 On handshake with n=N_NEURON-1: DONE=1 next cycle, BUSY=0 with DONE, next IDLE.
REQ-024 RES_READY low SHALL stall indefinitely in OUT; no new CORE_EN issued while stalled.
REQ-025 START coincident with DONE SHALL be ignored; a new pass needs START in IDLE.
REQ-026 Minimum pass length with RES_READY tied 1: N_NEURON*(CORE_LAT+2)+1 cycles START->DONE.

Reset
REQ-027 RESET_X=0 at a rising CLK edge SHALL force IDLE, n=0, and BUSY, CORE_EN, W_SEL, RES_VALID, RES_IDX, RES_DATA, DONE, MAX_IDX, MAX_VAL all 0.
REQ-028 Reset mid-pass SHALL abort without DONE; in-flight core result discarded.
REQ-029 START sampled while RESET_X=0 SHALL be ignored.

Configuration
REQ-030 Macro MUL_ADD_SEQ_ARGMAX_EN defined: MAX_VAL/MAX_IDX track the signed maximum captured RES_DATA of the pass; cleared to first result at n=0; ties keep lowest index; valid and held from DONE until next START.
REQ-031 Macro undefined: no compare logic, MAX_IDX and MAX_VAL tied 0.

Verification
REQ-032 Reset then START, RES_READY=1, core returns 100+W_SEL -> 46 results RES_IDX 0..45, RES_DATA 100..145, DONE at cycle 277.
REQ-033 RES_READY low 10 cycles at n=5 -> RES_VALID held, RES_DATA=105 stable, no CORE_EN until accept.
REQ-034 START pulses during BUSY and coincident with DONE -> ignored; exactly 46 CORE_EN per pass.
REQ-035 RESET_X low for 1 cycle at n=20 in WAIT -> all outputs 0, no DONE; subsequent START restarts at n=0.
REQ-036 ARGMAX_EN, results -5 except n=7 and n=30 equal 900 -> MAX_IDX=7, MAX_VAL=900 at DONE; macro off -> both 0.
REQ-037 CORE_LAT=1 and N_NEURON=1 -> single CORE_EN, DONE 4 cycles after START.

Source files
------------

// File: rtl/mul_add_seq.sv
// Sequences one pass of N_NEURON issues through a shared mul_add_core and hands each result out via valid/ready.
// Optional argmax tracking of the pass results is enabled by defining MUL_ADD_SEQ_ARGMAX_EN.
module mul_add_seq #(
   parameter int N_NEURON = 46,
   parameter int CORE_LAT = 4
) (
   input  logic        CLK,
   input  logic        RESET_X,
   input  logic        START,
   output logic        BUSY,
   output logic        CORE_EN,
   output logic [5:0]  W_SEL,
   input  logic [31:0] CORE_RESULT,
   output logic        RES_VALID,
   input  logic        RES_READY,
   output logic [5:0]  RES_IDX,
   output logic [31:0] RES_DATA,
   output logic        DONE,
   output logic [5:0]  MAX_IDX,
   output logic [31:0] MAX_VAL
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam logic [5:0] LAST_N   = 6'(N_NEURON - 1);
   localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

   state_t      state;
   logic [5:0]  n;
   logic [3:0]  lat_cnt;
   logic        capture;

   // The core result is valid in the CORE_LAT-th cycle after the CORE_EN cycle.
   assign capture = (state == WAIT) && (lat_cnt == LAT_LAST);

   always_ff @(posedge CLK) begin
      if (!RESET_X) begin
         state     <= IDLE;
         n         <= '0;
         lat_cnt   <= '0;
         BUSY      <= 1'b0;
         CORE_EN   <= 1'b0;
         W_SEL     <= '0;
         RES_VALID <= 1'b0;
         RES_IDX   <= '0;
         RES_DATA  <= '0;
         DONE      <= 1'b0;
      end else begin
         CORE_EN <= 1'b0;
         DONE    <= 1'b0;
         case (state)
            IDLE: begin
               // DONE high means the pass only just ended; such a START is dropped.
               if (START && !DONE) begin
                  n       <= '0;
                  W_SEL   <= '0;
                  BUSY    <= 1'b1;
                  CORE_EN <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (capture) begin
                  RES_DATA  <= CORE_RESULT;
                  RES_IDX   <= n;
                  RES_VALID <= 1'b1;
                  state     <= OUT;
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            OUT: begin
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  if (n == LAST_N) begin
                     DONE  <= 1'b1;
                     BUSY  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     n       <= n + 6'd1;
                     W_SEL   <= n + 6'd1;
                     CORE_EN <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUL_ADD_SEQ_ARGMAX_EN
   logic [5:0]  max_idx;
   logic [31:0] max_val;

   // Strict greater-than keeps the lowest index on ties.
   always_ff @(posedge CLK) begin
      if (!RESET_X) begin
         max_idx <= '0;
         max_val <= '0;
      end else if (capture) begin
         if ((n == 6'd0) || ($signed(CORE_RESULT) > $signed(max_val))) begin
            max_idx <= n;
            max_val <= CORE_RESULT;
         end
      end
   end

   assign MAX_IDX = max_idx;
   assign MAX_VAL = max_val;
`else
   assign MAX_IDX = '0;
   assign MAX_VAL = '0;
`endif

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: table-driven passes against a behavioural core and result model.
module tb_mul_add_seq;
   localparam int N   = 46;
   localparam int LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_x, start, busy, core_en, res_valid, res_ready, done;
   logic [5:0]  w_sel, res_idx, max_idx;
   logic [31:0] core_result, res_data, max_val;

   logic        b_start, b_busy, b_core_en, b_res_valid, b_res_ready, b_done;
   logic [5:0]  b_w_sel, b_res_idx, b_max_idx;
   logic [31:0] b_core_result, b_res_data, b_max_val;

   mul_add_seq #(.N_NEURON(N), .CORE_LAT(LAT)) dut (
      .CLK(clk), .RESET_X(reset_x), .START(start), .BUSY(busy), .CORE_EN(core_en),
      .W_SEL(w_sel), .CORE_RESULT(core_result), .RES_VALID(res_valid), .RES_READY(res_ready),
      .RES_IDX(res_idx), .RES_DATA(res_data), .DONE(done), .MAX_IDX(max_idx), .MAX_VAL(max_val)
   );

   mul_add_seq #(.N_NEURON(1), .CORE_LAT(1)) dut_b (
      .CLK(clk), .RESET_X(reset_x), .START(b_start), .BUSY(b_busy), .CORE_EN(b_core_en),
      .W_SEL(b_w_sel), .CORE_RESULT(b_core_result), .RES_VALID(b_res_valid), .RES_READY(b_res_ready),
      .RES_IDX(b_res_idx), .RES_DATA(b_res_data), .DONE(b_done), .MAX_IDX(b_max_idx), .MAX_VAL(b_max_val)
   );

   int checks = 0;
   int errors = 0;
   int mode   = 0;
   int rvals[64];

   typedef struct {
      int mode;
      int stall_n;
      int stall_len;
      int rand_ready;
      int start_noise;
      int exp_cycles;
      int exp_cen;
   } vec_t;

   vec_t vecs[6];

   function automatic int model_val(int m, int k);
      case (m)
         0:       return 100 + k;
         1:       return (k == 7 || k == 30) ? 900 : -5;
         default: return rvals[k];
      endcase
   endfunction

   function automatic int exp_max_val(int m);
`ifdef MUL_ADD_SEQ_ARGMAX_EN
      int best = model_val(m, 0);
      for (int k = 1; k < N; k++) if (model_val(m, k) > best) best = model_val(m, k);
      return best;
`else
      return m * 0;
`endif
   endfunction

   function automatic int exp_max_idx(int m);
`ifdef MUL_ADD_SEQ_ARGMAX_EN
      for (int k = 0; k < N; k++) if (model_val(m, k) == exp_max_val(m)) return k;
      return -1;
`else
      return m * 0;
`endif
   endfunction

   // Behavioural core: result of the W_SEL seen with CORE_EN appears exactly LAT cycles later.
   logic [LAT-1:0] pv = '0;
   logic [31:0]    pd [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], core_en};
      pd[0] <= 32'(model_val(mode, int'(w_sel)));
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign core_result = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0BAD0;

   logic        bpv = 1'b0;
   logic [31:0] bpd;
   always @(posedge clk) begin
      bpv <= b_core_en;
      bpd <= 32'd77 + {26'd0, b_w_sel};
   end
   assign b_core_result = bpv ? bpd : 32'hBAD0BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      32'(busy),      0);
      chk({tag, "_core_en"},   32'(core_en),   0);
      chk({tag, "_w_sel"},     32'(w_sel),     0);
      chk({tag, "_res_valid"}, 32'(res_valid), 0);
      chk({tag, "_res_idx"},   32'(res_idx),   0);
      chk({tag, "_res_data"},  res_data,       0);
      chk({tag, "_done"},      32'(done),      0);
      chk({tag, "_max_idx"},   32'(max_idx),   0);
      chk({tag, "_max_val"},   max_val,        0);
   endtask

   task automatic run_pass(input vec_t v);
      int cyc, k, cen, used;
      bit done_seen;
      mode = v.mode;
      @(negedge clk);
      start = 1'b1; res_ready = 1'b1;
      cyc = 0; k = 0; cen = 0; used = 0; done_seen = 0;
      while (!done_seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = (v.start_noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (core_en) begin
            cen++;
            chk("w_sel_at_issue", 32'(w_sel), 32'(k));
         end
         if (done) begin
            done_seen = 1;
            if (v.start_noise != 0) start = 1'b1;
         end else if (res_valid) begin
            chk("res_idx", 32'(res_idx), 32'(k));
            chk("res_data", res_data, 32'(model_val(mode, k)));
            chk("w_sel_held", 32'(w_sel), 32'(k));
            chk("no_issue_while_out", 32'(core_en), 0);
            if (k == v.stall_n && used < v.stall_len) begin
               res_ready = 1'b0;
               used++;
            end else if (v.rand_ready != 0) begin
               res_ready = 1'($urandom_range(0, 1));
            end else begin
               res_ready = 1'b1;
            end
            if (res_ready) k++;
         end else begin
            res_ready = 1'b1;
         end
      end
      chk("done_seen", 32'(done_seen), 1);
      if (v.exp_cycles != 0) chk("done_cycle", 32'(cyc), 32'(v.exp_cycles));
      chk("result_count", 32'(k), 32'(N));
      chk("core_en_count", 32'(cen), 32'(v.exp_cen));
      chk("busy_low_at_done", 32'(busy), 0);
      chk("max_idx", 32'(max_idx), 32'(exp_max_idx(mode)));
      chk("max_val", max_val, 32'(exp_max_val(mode)));
      @(negedge clk);
      start = 1'b0;
      chk("done_one_pulse", 32'(done), 0);
      chk("start_at_done_ignored", 32'(busy), 0);
      repeat (2) @(negedge clk);
      chk("idle_no_issue", 32'(core_en), 0);
      chk("max_val_held", max_val, 32'(exp_max_val(mode)));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, cen, dc, dcount;
      bit hit;

      for (int i = 0; i < 64; i++) rvals[i] = int'($urandom_range(0, 40)) - 20;
      //           mode stall_n len rr noise cycles cen
      vecs[0] = '{0, -1, 0,  0, 0, 277, 46};
      vecs[1] = '{0,  5, 10, 0, 0, 287, 46};
      vecs[2] = '{0, -1, 0,  0, 1, 277, 46};
      vecs[3] = '{1, -1, 0,  0, 0, 277, 46};
      vecs[4] = '{2, -1, 0,  1, 1, 0,   46};
      vecs[5] = '{2, -1, 0,  0, 0, 277, 46};

      reset_x = 1'b0; start = 1'b0; res_ready = 1'b1; b_start = 1'b0; b_res_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("b_reset_busy", 32'(b_busy), 0);
      chk("b_reset_res_data", b_res_data, 0);
      reset_x = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_pass(vecs[v]);

      // Abort in WAIT for n=20, with START asserted during the reset edge.
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      cyc = 0; hit = 0;
      while (!hit && cyc < 1000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (busy && !core_en && !res_valid && w_sel == 6'd20) hit = 1;
      end
      chk("reached_n20_wait", 32'(hit), 1);
      reset_x = 1'b0; start = 1'b1;
      @(negedge clk);
      reset_x = 1'b1; start = 1'b0;
      chk_all_zero("midpass_reset");
      dcount = 0; cen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcount++;
         if (core_en || busy) cen++;
      end
      chk("no_done_after_abort", 32'(dcount), 0);
      chk("start_in_reset_ignored", 32'(cen), 0);
      run_pass(vecs[0]);

      // Minimal configuration: one neuron, one-cycle core.
      @(negedge clk);
      b_start = 1'b1;
      cen = 0; dc = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         b_start = 1'b0;
         if (b_core_en) cen++;
         if (b_done && dc == 0) dc = c;
         if (b_res_valid) begin
            chk("b_res_idx", 32'(b_res_idx), 0);
            chk("b_res_data", b_res_data, 77);
         end
      end
      chk("b_done_cycle", 32'(dc), 4);
      chk("b_core_en_count", 32'(cen), 1);
`ifdef MUL_ADD_SEQ_ARGMAX_EN
      chk("b_max_val", b_max_val, 77);
`else
      chk("b_max_val", b_max_val, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
